conv_window_feeder: RTL and testbench

//  Drives a single binary-weight conv cell: scans a feature map in on-chip RAM, one 3x3 window
//  per output position (stride 1, no padding). Streams the 9 Q4.8 samples serially into the cell,

---
 rtl/conv_window_feeder.sv | 249 ++++++++++++++++++++++++
 tb/tb_conv_window_feeder.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_feeder.sv
// Feeds 3x3 feature-map windows (stride 1, no padding) serially into a binary-weight conv cell
// and returns each Q8.8 result, tagged with its output position, over a valid/ready port.
module conv_window_feeder #(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int AW      = 10,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [11:0]   mem_rdata,
    output logic          conv_rst,
    output logic          conv_en,
    output logic [11:0]   conv_data,
    input  logic          conv_finish,
    input  logic [15:0]   conv_out,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [15:0]   res_data,
    output logic [7:0]    res_row,
    output logic [7:0]    res_col
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [7:0]    LAST_ROW  = 8'(IMG_H - 3);
    localparam logic [7:0]    LAST_COL  = 8'(IMG_W - 3);
    localparam logic [AW-1:0] ROW_STEP  = AW'(IMG_W);
    localparam logic [AW-1:0] LINE_STEP = AW'(IMG_W - 2);
    localparam logic [AW-1:0] PIX_STEP  = AW'(32'd1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_SYNC   = 3'd2,
        S_STREAM = 3'd3,
        S_WAIT   = 3'd4,
        S_OUT    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic          xfer_s;
    logic          timeout_s;
    logic          last_win_s;
    logic          scan_start_s;

    logic          busy_r;
    logic          done_r;
    logic          err_r;
    logic          conv_rst_r;
    logic          conv_en_r;
    logic          stream_on_r;
    logic          res_valid_r;
    logic [15:0]   res_data_r;
    logic [7:0]    res_row_r;
    logic [7:0]    res_col_r;

    logic          mem_rd_en_r;
    logic [AW-1:0] mem_addr_r;
    logic [3:0]    rd_k_r;
    logic [1:0]    rd_c_r;

    logic [7:0]    win_row_r;
    logic [7:0]    win_col_r;
    logic [AW-1:0] row_base_r;
    logic [3:0]    stream_cnt_r;
    logic [TW-1:0] wait_cnt_r;

    assign last_win_s   = (win_row_r == LAST_ROW) && (win_col_r == LAST_COL);
    assign scan_start_s = (state_r == S_IDLE) && start;

    // Next-state decode plus the single-cycle transfer/timeout strobes
    always_comb begin
        state_next_s = state_r;
        xfer_s       = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s = S_CLR;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_CLR:  state_next_s = S_SYNC;
            S_SYNC: state_next_s = S_STREAM;
            S_STREAM: begin
                if (stream_cnt_r == 4'd8) begin
                    state_next_s = S_WAIT;
                end else begin
                    state_next_s = S_STREAM;
                end
            end
            S_WAIT: begin
                if (conv_finish) begin
                    state_next_s = S_OUT;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    timeout_s    = 1'b1;
                    state_next_s = S_OUT;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    xfer_s = 1'b1;
                    if (last_win_s) begin
                        state_next_s = S_DONE;
                    end else begin
                        state_next_s = S_CLR;
                    end
                end else begin
                    state_next_s = S_OUT;
                end
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register; control outputs are decoded from the next state so they leave flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            conv_rst_r  <= 1'b0;
            conv_en_r   <= 1'b0;
            stream_on_r <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            busy_r      <= (state_next_s != S_IDLE);
            done_r      <= (state_next_s == S_DONE);
            conv_rst_r  <= (state_next_s == S_CLR);
            conv_en_r   <= (state_next_s == S_STREAM) || (state_next_s == S_WAIT);
            stream_on_r <= (state_next_s == S_STREAM);
            res_valid_r <= (state_next_s == S_OUT);
        end
    end

    // Sample counter for STREAM and finish-timeout counter for WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            stream_cnt_r <= 4'd0;
            wait_cnt_r   <= '0;
        end else begin
            stream_cnt_r <= (state_r == S_STREAM) ? (stream_cnt_r + 4'd1) : 4'd0;
            wait_cnt_r   <= (state_r == S_WAIT) ? (wait_cnt_r + TW'(32'd1)) : '0;
        end
    end

    // Read sequencer: one read per cycle, stepping +1 along a line and jumping to the next line after c=2
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd_en_r <= 1'b0;
            mem_addr_r  <= '0;
            rd_k_r      <= 4'd0;
            rd_c_r      <= 2'd0;
        end else if (state_r == S_CLR) begin
            mem_rd_en_r <= 1'b1;
            mem_addr_r  <= row_base_r + AW'(win_col_r);
            rd_k_r      <= 4'd0;
            rd_c_r      <= 2'd0;
        end else if (mem_rd_en_r) begin
            if (rd_k_r == 4'd8) begin
                mem_rd_en_r <= 1'b0;
            end else begin
                rd_k_r     <= rd_k_r + 4'd1;
                mem_addr_r <= mem_addr_r + ((rd_c_r == 2'd2) ? LINE_STEP : PIX_STEP);
                rd_c_r     <= (rd_c_r == 2'd2) ? 2'd0 : (rd_c_r + 2'd1);
            end
        end
    end

    // Window position; row_base tracks row*IMG_W so no multiplier is needed
    always_ff @(posedge clk) begin
        if (rst) begin
            win_row_r  <= 8'd0;
            win_col_r  <= 8'd0;
            row_base_r <= '0;
        end else if (scan_start_s) begin
            win_row_r  <= 8'd0;
            win_col_r  <= 8'd0;
            row_base_r <= '0;
        end else if (xfer_s && !last_win_s) begin
            if (win_col_r == LAST_COL) begin
                win_col_r  <= 8'd0;
                win_row_r  <= win_row_r + 8'd1;
                row_base_r <= row_base_r + ROW_STEP;
            end else begin
                win_col_r <= win_col_r + 8'd1;
            end
        end
    end

    // Result capture: cell output on finish, zero on timeout; held through OUT
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data_r <= 16'h0000;
            res_row_r  <= 8'd0;
            res_col_r  <= 8'd0;
        end else if ((state_r == S_WAIT) && conv_finish) begin
            res_data_r <= conv_out;
            res_row_r  <= win_row_r;
            res_col_r  <= win_col_r;
        end else if (timeout_s) begin
            res_data_r <= 16'h0000;
            res_row_r  <= win_row_r;
            res_col_r  <= win_col_r;
        end
    end

    // Sticky timeout flag, cleared when a new scan is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (scan_start_s) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end
    end

    // RAM data is only forwarded while streaming; the read latency is already absorbed by SYNC
    assign conv_data = stream_on_r ? mem_rdata : 12'h000;

    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign mem_rd_en = mem_rd_en_r;
    assign mem_addr  = mem_addr_r;
    assign conv_rst  = conv_rst_r;
    assign conv_en   = conv_en_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_row   = res_row_r;
    assign res_col   = res_col_r;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder on a 4x4 map: RAM and conv-cell models, result/address monitors,
// table vectors, hand-written corner sequences and randomized scans against a window-sum model.
module tb_conv_window_feeder;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, err;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [11:0]   mem_rdata;
    logic          conv_rst, conv_en, conv_finish;
    logic [11:0]   conv_data;
    logic [15:0]   conv_out;
    logic          res_valid, res_ready;
    logic [15:0]   res_data;
    logic [7:0]    res_row, res_col;

    always #5 clk = ~clk;

    conv_window_feeder #(.IMG_W(W), .IMG_H(H), .AW(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .conv_rst(conv_rst), .conv_en(conv_en), .conv_data(conv_data),
        .conv_finish(conv_finish), .conv_out(conv_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_row(res_row), .res_col(res_col)
    );

    typedef struct {
        int row;
        int col;
        int data;
    } res_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read RAM, data one cycle after the read enable
    logic [11:0] ram [16];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= ram[mem_addr[3:0]];
    end

    // Conv cell: sums up to 9 enabled samples, finish when all 9 are in (unless suppressed)
    int          cm_cnt = 0;
    int          cm_win = -1;
    int          suppress_idx = -1;
    logic [15:0] cm_sum = 16'h0000;
    always @(posedge clk) begin
        if (conv_rst) begin
            cm_cnt <= 0;
            cm_sum <= 16'h0000;
            cm_win <= cm_win + 1;
        end else begin
            if (start) cm_win <= -1;
            if (conv_en && cm_cnt < 9) begin
                cm_sum <= cm_sum + {4'h0, conv_data};
                cm_cnt <= cm_cnt + 1;
            end
        end
    end
    assign conv_finish = (cm_cnt == 9) && (cm_win != suppress_idx);
    assign conv_out    = cm_sum;

    // Monitors sample away from the active edge
    res_t got_q[$];
    int   addr_q[$];
    int   done_cnt = 0;
    int   done_cyc = 0;
    always @(negedge clk) begin
        if (res_valid && res_ready)
            got_q.push_back('{row: int'(res_row), col: int'(res_col), data: int'(res_data)});
        if (mem_rd_en) addr_q.push_back(int'(mem_addr));
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit rand_rdy);
        int base;
        bit seen;
        base = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rand_rdy) res_ready = 1'($urandom_range(0, 1));
            tick();
            if (done_cnt > base) begin
                seen = 1'b1;
                break;
            end
        end
        res_ready = 1'b1;
        check({tag, "_done_seen"}, seen, 1);
        tick();
        tick();
    endtask

    task automatic wait_clr(input string tag, input int nth, output int c);
        int n;
        n = 0;
        c = -1;
        for (int i = 0; i < 300; i++) begin
            if (conv_rst) begin
                n++;
                if (n == nth) begin
                    c = cyc;
                    break;
                end
            end
            tick();
        end
        check({tag, "_clr_found"}, (c >= 0), 1);
    endtask

    // Reference: every window result is the plain sum of its 9 RAM samples, in raster order
    res_t exp_q[$];
    function automatic void fill_expected(input int sup);
        int s, idx;
        exp_q.delete();
        idx = 0;
        for (int r = 0; r <= H - 3; r++) begin
            for (int c = 0; c <= W - 3; c++) begin
                s = 0;
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        s += int'(ram[(r + dr) * W + c + dc]);
                exp_q.push_back('{row: r, col: c, data: (idx == sup) ? 0 : (s & 16'hFFFF)});
                idx++;
            end
        end
    endfunction

    task automatic check_scan(input string tag, input int b);
        int n;
        check({tag, "_count"}, got_q.size() - b, exp_q.size());
        n = (got_q.size() - b < exp_q.size()) ? got_q.size() - b : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_row%0d", tag, i),  got_q[b + i].row,  exp_q[i].row);
            check($sformatf("%s_col%0d", tag, i),  got_q[b + i].col,  exp_q[i].col);
            check($sformatf("%s_data%0d", tag, i), got_q[b + i].data, exp_q[i].data);
        end
    endtask

    res_t case1_tab[4];
    int   addr00_tab[9];
    int   addr11_tab[9];

    task automatic check_case1(input string tag, input int b);
        check({tag, "_count"}, got_q.size() - b, 4);
        for (int i = 0; i < 4; i++) begin
            if (b + i < got_q.size()) begin
                check($sformatf("%s_row%0d", tag, i),  got_q[b + i].row,  case1_tab[i].row);
                check($sformatf("%s_col%0d", tag, i),  got_q[b + i].col,  case1_tab[i].col);
                check($sformatf("%s_data%0d", tag, i), got_q[b + i].data, case1_tab[i].data);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_res, b_addr, b_done, s_cyc, c_clr, r_d, r_r, r_c;
        bit seen, prev_err;

        case1_tab  = '{'{0, 0, 45}, '{0, 1, 54}, '{1, 0, 81}, '{1, 1, 90}};
        addr00_tab = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        addr11_tab = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        for (int i = 0; i < 16; i++) ram[i] = 12'(i);

        rst = 1'b1; start = 1'b0; res_ready = 1'b1;
        repeat (3) tick();
        check("reset_busy", busy, 0);
        check("reset_ctrl", {done, err, mem_rd_en, conv_rst, conv_en, res_valid}, 0);
        check("reset_data", {mem_addr, conv_data, res_data, res_row, res_col}, 0);
        rst = 1'b0;
        tick();

        // Full scan with ready tied high: results, addresses, latency
        b_res = got_q.size(); b_addr = addr_q.size(); b_done = done_cnt;
        s_cyc = cyc;
        pulse_start();
        check("t1_busy", busy, 1);
        wait_done("t1", 200, 1'b0);
        check("t1_done_latency", done_cyc - s_cyc, 53);
        check("t1_done_pulses", done_cnt - b_done, 1);
        check("t1_idle", busy, 0);
        check_case1("t1", b_res);
        check("t2_addr_count", addr_q.size() - b_addr, 36);
        if (addr_q.size() - b_addr >= 36) begin
            for (int k = 0; k < 9; k++) begin
                check($sformatf("t2_addr00_%0d", k), addr_q[b_addr + k], addr00_tab[k]);
                check($sformatf("t2_addr11_%0d", k), addr_q[b_addr + 27 + k], addr11_tab[k]);
            end
        end

        // Backpressure: result held stable while ready is low
        b_res = got_q.size();
        res_ready = 1'b0;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (res_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("t3_valid_seen", seen, 1);
        r_d = int'(res_data); r_r = int'(res_row); r_c = int'(res_col);
        check("t3_first_data", r_d, 45);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_valid", res_valid, 1);
            check("t3_hold_fields", {res_data, res_row, res_col}, {16'(r_d), 8'(r_r), 8'(r_c)});
        end
        res_ready = 1'b1;
        tick();
        check("t3_next_clr", conv_rst, 1);
        check("t3_valid_drop", res_valid, 0);
        wait_done("t3", 200, 1'b0);
        fill_expected(-1);
        check_scan("t3", b_res);

        // Missing finish on window (0,1): timeout, zero result, sticky err
        suppress_idx = 1;
        b_res = got_q.size(); b_done = done_cnt;
        s_cyc = cyc;
        pulse_start();
        wait_clr("t4", 2, c_clr);
        prev_err = 1'b0;
        for (int i = 0; i < 100; i++) begin
            prev_err = err;
            tick();
            if (res_valid) break;
        end
        check("t4_timeout_latency", cyc - c_clr, 27);
        check("t4_err_not_early", prev_err, 0);
        check("t4_err_set", err, 1);
        check("t4_zero_result", {res_data, res_row, res_col}, {16'h0000, 8'd0, 8'd1});
        wait_done("t4", 200, 1'b0);
        check("t4_done_latency", done_cyc - s_cyc, 68);
        check("t4_done_pulses", done_cnt - b_done, 1);
        check("t4_err_sticky", err, 1);
        fill_expected(1);
        check_scan("t4", b_res);
        suppress_idx = -1;

        // Reset during STREAM of window (1,0), then a clean rescan
        b_res = got_q.size(); b_done = done_cnt;
        pulse_start();
        check("t5_err_cleared", err, 0);
        wait_clr("t5", 3, c_clr);
        tick(); tick(); tick();
        check("t5_streaming", conv_en, 1);
        rst = 1'b1;
        tick();
        check("t5_rst_busy", busy, 0);
        check("t5_rst_ctrl", {done, err, mem_rd_en, conv_rst, conv_en, res_valid}, 0);
        check("t5_rst_data", {mem_addr, conv_data, res_data, res_row, res_col}, 0);
        rst = 1'b0;
        repeat (3) tick();
        check("t5_stays_idle", busy, 0);
        check("t5_partial_results", got_q.size() - b_res, 2);
        check("t5_no_done", done_cnt - b_done, 0);
        b_res = got_q.size();
        s_cyc = cyc;
        pulse_start();
        wait_done("t5", 200, 1'b0);
        check("t5_done_latency", done_cyc - s_cyc, 53);
        check_case1("t5", b_res);

        // start pulsed again while busy is ignored
        b_res = got_q.size(); b_done = done_cnt;
        pulse_start();
        repeat (20) tick();
        pulse_start();
        wait_done("t6", 200, 1'b0);
        repeat (30) tick();
        check("t6_idle", busy, 0);
        check("t6_done_pulses", done_cnt - b_done, 1);
        check("t6_result_count", got_q.size() - b_res, 4);

        // Random RAM contents and random downstream ready
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 16; i++) ram[i] = 12'($urandom);
            b_res = got_q.size(); b_done = done_cnt;
            pulse_start();
            wait_done($sformatf("rnd%0d", it), 600, 1'b1);
            check($sformatf("rnd%0d_done_pulses", it), done_cnt - b_done, 1);
            check($sformatf("rnd%0d_err", it), err, 0);
            fill_expected(-1);
            check_scan($sformatf("rnd%0d", it), b_res);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
